alu_sequencer: RTL and testbench

Command-driven controller that sits in front of the combinational `ALU_A1` add/subtract unit and drives its operand and select inputs. It accepts operation requests over a valid/ready handshake and sequences the ALU: one cycle for ADD/SUB/CMP, and `bits` cycles of shift-add for MUL. It captures the ALU outputs into result and flag registers and returns them over a second valid/ready handshake. It is the issuing/consuming end of the ALU's RA/RB/s → out/carry_out/zero_flag interface.

---
 rtl/alu_sequencer.sv | 157 +++++++++++++++
 tb/tb_alu_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: command-driven controller for a combinational add/subtract
// ALU. Runs ADD/SUB/CMP in one ALU cycle and MUL as a bits-step shift-add,
// then holds the result and flags until the consumer takes them.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high. The producer keeps valid and its payload stable until that
// edge, and ready never depends combinationally on valid.
module alu_sequencer #(
  parameter int bits = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [bits-1:0]     cmd_a,
  input  logic [bits-1:0]     cmd_b,
  output logic [bits-1:0]     RA,
  output logic [bits-1:0]     RB,
  output logic                s,
  input  logic [bits-1:0]     alu_out,
  input  logic                alu_carry,
  input  logic                alu_zero,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [2*bits-1:0]   rsp_result,
  output logic                rsp_carry,
  output logic                rsp_zero,
  output logic [1:0]          dbg_state_o
);

  localparam int SW = (bits > 1) ? $clog2(bits) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(bits - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    MUL_STEP = 2'd2,
    RESP     = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [bits-1:0]     a_q, b_q;
  logic [1:0]          op_q;
  logic [bits-1:0]     p_hi_q, p_lo_q;
  logic [SW-1:0]       step_q;
  logic [2*bits-1:0]   rsp_result_q;
  logic                rsp_carry_q;
  logic                rsp_zero_q;
  logic [2*bits-1:0]   prod_next;
  logic                accept;

  assign accept      = (state_q == IDLE) && cmd_valid;
  assign rsp_result  = rsp_result_q;
  assign rsp_carry   = rsp_carry_q;
  assign rsp_zero    = rsp_zero_q;
  assign dbg_state_o = state_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (cmd_valid) state_d = (cmd_op == OP_MUL) ? MUL_STEP : EXEC;
      EXEC:     state_d = RESP;
      MUL_STEP: if (step_q == LAST_STEP) state_d = RESP;
      RESP:     if (rsp_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state so the ALU inputs settle early in the cycle.
  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    RA        = '0;
    RB        = '0;
    s         = 1'b0;
    case (state_q)
      IDLE: cmd_ready = 1'b1;
      EXEC: begin
        RA = a_q;
        RB = b_q;
        s  = (op_q == OP_SUB) || (op_q == OP_CMP);
      end
      MUL_STEP: begin
        RA = p_hi_q;
        RB = a_q;
      end
      RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // One shift-add step: add the multiplicand into the high half when the
  // current multiplier bit is set, then shift the whole product right by one.
  always_comb begin
    if (p_lo_q[0]) prod_next = {alu_carry, alu_out, p_lo_q[bits-1:1]};
    else           prod_next = {1'b0, p_hi_q, p_lo_q[bits-1:1]};
  end

  // Operand capture, multiply accumulator and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      p_hi_q       <= '0;
      p_lo_q       <= '0;
      step_q       <= '0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q    <= cmd_a;
            b_q    <= cmd_b;
            op_q   <= cmd_op;
            p_hi_q <= '0;
            p_lo_q <= cmd_b;
            step_q <= '0;
          end
        end
        EXEC: begin
          // Borrow is derived from the operands; the ALU carry is only
          // meaningful on the add path.
          rsp_result_q <= (op_q == OP_CMP) ? '0 : {{bits{1'b0}}, alu_out};
          rsp_carry_q  <= (op_q == OP_ADD) ? alu_carry : (a_q < b_q);
          rsp_zero_q   <= alu_zero;
        end
        MUL_STEP: begin
          {p_hi_q, p_lo_q} <= prod_next;
          step_q           <= step_q + SW'(1);
          if (step_q == LAST_STEP) begin
            rsp_result_q <= prod_next;
            rsp_carry_q  <= 1'b0;
            rsp_zero_q   <= (prod_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU, table of directed vectors,
// hand-written multi-cycle sequences and randomized traffic against a model.
module tb_alu_sequencer;

  localparam int BITS = 8;

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [BITS-1:0]   cmd_a, cmd_b;
  logic [BITS-1:0]   RA, RB;
  logic              s;
  logic [BITS-1:0]   alu_out;
  logic              alu_carry;
  logic              alu_zero;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [2*BITS-1:0] rsp_result;
  logic              rsp_carry;
  logic              rsp_zero;
  logic [1:0]        dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [2*BITS+1:0] exp_q[$];

  alu_sequencer #(.bits(BITS)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .RA         (RA),
    .RB         (RB),
    .s          (s),
    .alu_out    (alu_out),
    .alu_carry  (alu_carry),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_zero   (rsp_zero),
    .dbg_state_o(dbg_state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU_A1 behaviour.
  logic [BITS:0] alu_full;
  always_comb begin
    alu_full  = s ? ({1'b0, RA} - {1'b0, RB}) : ({1'b0, RA} + {1'b0, RB});
    alu_out   = alu_full[BITS-1:0];
    alu_carry = alu_full[BITS];
    alu_zero  = (alu_full[BITS-1:0] == '0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: {result, carry, zero} from plain unsigned arithmetic.
  function automatic logic [2*BITS+1:0] model(input logic [1:0] op, input logic [BITS-1:0] a,
                                              input logic [BITS-1:0] b);
    int unsigned ai, bi, r;
    logic [15:0] res;
    logic c, z;
    ai = a; bi = b;
    res = '0; c = 1'b0; z = 1'b0;
    case (op)
      2'd0: begin r = (ai + bi) % 256; res = 16'(r); c = (ai + bi) > 255; z = (r == 0); end
      2'd1: begin r = (ai + 256 - bi) % 256; res = 16'(r); c = ai < bi; z = (r == 0); end
      2'd2: begin res = 16'd0; c = ai < bi; z = (ai == bi); end
      default: begin r = ai * bi; res = 16'(r); c = 1'b0; z = (r == 0); end
    endcase
    return {res, c, z};
  endfunction

  function automatic int model_lat(input logic [1:0] op);
    return (op == 2'd3) ? BITS + 1 : 2;
  endfunction

  // Issue one command, wait for its response, consume it after rdy_delay cycles.
  // Entered and left #1 after a rising edge.
  task automatic do_cmd(input logic [1:0] op, input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                        input int rdy_delay,
                        output logic [2*BITS-1:0] res, output logic c, output logic z,
                        output int lat, output logic [BITS-1:0] ra1, output logic [BITS-1:0] rb1,
                        output logic s1, output logic ready_after);
    int guard;
    guard = 0;
    while (!cmd_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_a = BITS'($urandom); cmd_b = BITS'($urandom); cmd_op = 2'($urandom);
    ra1 = RA; rb1 = RB; s1 = s;
    lat = 1;
    while (!rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    check("rsp_valid_wait", 32'(rsp_valid), 32'd1);
    repeat (rdy_delay) begin @(posedge clk); #1; end
    res = rsp_result; c = rsp_carry; z = rsp_zero;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    ready_after = cmd_ready;
  endtask

  typedef struct {
    logic [1:0]        op;
    logic [BITS-1:0]   a;
    logic [BITS-1:0]   b;
    logic [2*BITS-1:0] res;
    logic              c;
    logic              z;
    int                lat;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [2*BITS-1:0] res;
    logic c, z, s1, rdy_after, any_valid;
    logic [BITS-1:0] ra1, rb1;
    logic [2*BITS+1:0] exp;
    logic [1:0] op;
    logic [BITS-1:0] a, b;
    int lat, guard;

    vecs[0] = '{2'd0, 8'd200, 8'd100, 16'h002C, 1'b1, 1'b0, 2};
    vecs[1] = '{2'd1, 8'd5,   8'd5,   16'h0000, 1'b0, 1'b1, 2};
    vecs[2] = '{2'd1, 8'd3,   8'd5,   16'h00FE, 1'b1, 1'b0, 2};
    vecs[3] = '{2'd3, 8'd255, 8'd255, 16'hFE01, 1'b0, 1'b0, 9};
    vecs[4] = '{2'd3, 8'd0,   8'd37,  16'h0000, 1'b0, 1'b1, 9};
    vecs[5] = '{2'd3, 8'd13,  8'd11,  16'h008F, 1'b0, 1'b0, 9};
    vecs[6] = '{2'd2, 8'd7,   8'd7,   16'h0000, 1'b0, 1'b1, 2};
    vecs[7] = '{2'd2, 8'd2,   8'd9,   16'h0000, 1'b1, 1'b0, 2};
    vecs[8] = '{2'd0, 8'd255, 8'd1,   16'h0000, 1'b1, 1'b1, 2};

    // Reset.
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_result", 32'(rsp_result), 32'd0);
    check("reset_rsp_flags", 32'({rsp_carry, rsp_zero}), 32'd0);
    check("reset_alu_drive", 32'({RA, RB, s}), 32'd0);

    // Directed vectors.
    for (int i = 0; i < 9; i++) begin
      do_cmd(vecs[i].op, vecs[i].a, vecs[i].b, i % 2, res, c, z, lat, ra1, rb1, s1, rdy_after);
      check($sformatf("vec%0d_result", i), 32'(res), 32'(vecs[i].res));
      check($sformatf("vec%0d_carry", i), 32'(c), 32'(vecs[i].c));
      check($sformatf("vec%0d_zero", i), 32'(z), 32'(vecs[i].z));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_s", i), 32'(s1), 32'(vecs[i].op == 2'd1 || vecs[i].op == 2'd2));
      check($sformatf("vec%0d_ready_after", i), 32'(rdy_after), 32'd1);
    end

    // Backpressure: response held 5 cycles, a stray command pulsed meanwhile.
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_a = 8'd1; cmd_b = 8'd1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    guard = 0;
    while (!rsp_valid && guard < 50) begin @(posedge clk); #1; guard++; end
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp_result_stable", 32'(rsp_result), 32'h0002);
      check("bp_cmd_ready_low", 32'(cmd_ready), 32'd0);
      check("bp_valid_held", 32'(rsp_valid), 32'd1);
      if (i == 1) begin cmd_valid = 1'b1; cmd_op = 2'd3; cmd_a = 8'd9; cmd_b = 8'd9; end
      if (i == 2) cmd_valid = 1'b0;
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("bp_ready_after", 32'(cmd_ready), 32'd1);
    any_valid = 1'b0;
    repeat (14) begin @(posedge clk); #1; any_valid |= rsp_valid; end
    check("bp_stray_not_run", 32'(any_valid), 32'd0);

    // Reset during MUL step 4.
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_a = 8'd200; cmd_b = 8'd3;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("mul_step0_RB", 32'(RB), 32'd200);
    repeat (4) begin @(posedge clk); #1; end
    check("mul_step4_busy", 32'(cmd_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("midrst_rsp", 32'({rsp_valid, rsp_result, rsp_carry, rsp_zero}), 32'd0);
    check("midrst_alu_drive", 32'({RA, RB, s}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_ready_release", 32'(cmd_ready), 32'd1);
    any_valid = 1'b0;
    repeat (15) begin @(posedge clk); #1; any_valid |= rsp_valid; end
    check("midrst_no_rsp", 32'(any_valid), 32'd0);
    do_cmd(2'd0, 8'd7, 8'd8, 0, res, c, z, lat, ra1, rb1, s1, rdy_after);
    check("post_rst_add", 32'(res), 32'h000F);
    check("post_rst_flags", 32'({c, z}), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: a = 8'd0;
        1: a = 8'd255;
        default: a = 8'($urandom);
      endcase
      b = ($urandom_range(0, 4) == 0) ? a : 8'($urandom);
      exp_q.push_back(model(op, a, b));
      do_cmd(op, a, b, $urandom_range(0, 3), res, c, z, lat, ra1, rb1, s1, rdy_after);
      exp = exp_q.pop_front();
      check($sformatf("rnd%0d_result op=%0d a=%0d b=%0d", i, op, a, b), 32'(res), 32'(exp[2*BITS+1:2]));
      check($sformatf("rnd%0d_carry", i), 32'(c), 32'(exp[1]));
      check($sformatf("rnd%0d_zero", i), 32'(z), 32'(exp[0]));
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(model_lat(op)));
      check($sformatf("rnd%0d_RA", i), 32'(ra1), (op == 2'd3) ? 32'd0 : 32'(a));
      check($sformatf("rnd%0d_RB", i), 32'(rb1), (op == 2'd3) ? 32'(a) : 32'(b));
      check($sformatf("rnd%0d_s", i), 32'(s1), 32'(op == 2'd1 || op == 2'd2));
      check($sformatf("rnd%0d_ready_after", i), 32'(rdy_after), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
